dmem_wb_ram: RTL and testbench

DMEM_WB_RAM -- requirements
Module: dmem_wb_ram

---
 rtl/dmem_wb_ram.sv | 110 +++++++++++
 tb/tb_dmem_wb_ram.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_wb_ram.sv
// dmem_wb_ram: Wishbone data RAM with byte/half/word lanes and configurable wait states.
// Build option: define MISALIGN_ERR_EN to report misaligned half/word accesses with oErr;
// otherwise misaligned addresses are forced aligned and complete with oAck.
// Ports: iClk clock, nRst async active-low reset, iCyc/iStb/iWe/iWidth/iAddr/iData request,
//        oData right-justified read data (valid only in the response cycle), oAck/oErr one-cycle pulses.
module dmem_wb_ram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iCyc,
  input  logic        iStb,
  input  logic        iWe,
  input  logic [1:0]  iWidth,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oAck,
  output logic        oErr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic we_q;
  logic [1:0] width_q;
  logic [AW+1:0] addr_q;
  logic [31:0] data_q;
  logic err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH];
  logic req, enter, bad, wr_en;
  logic c_we;
  logic [1:0] c_width;
  logic [AW+1:0] c_addr, a;
  logic [31:0] c_data, wdat, sh, rd;
  logic [3:0] be;
  logic unused_addr;
  assign unused_addr = ^iAddr[31:AW+2];
  assign req = iCyc & iStb;
  always_comb begin
    state_nx = state;
    cnt_nx = (state == WAIT) ? cnt + 4'd1 : '0;
    case (state)
      IDLE: if (req) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (!req) state_nx = IDLE;
            else if (cnt == LAST) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  // With zero wait states the access completes on the accept edge, so the
  // live request is used; otherwise the latched copy is.
  assign enter   = (state_nx == RESP);
  assign c_we    = (state == IDLE) ? iWe : we_q;
  assign c_width = (state == IDLE) ? iWidth : width_q;
  assign c_addr  = (state == IDLE) ? iAddr[AW+1:0] : addr_q;
  assign c_data  = (state == IDLE) ? iData : data_q;
`ifdef MISALIGN_ERR_EN
  assign bad = (c_width == 2'd1 && c_addr[0]) || (c_width[1] && c_addr[1:0] != 2'b00);
  assign a   = c_addr;
`else
  assign bad = 1'b0;
  assign a   = c_width[1] ? {c_addr[AW+1:2], 2'b00} : c_width[0] ? {c_addr[AW+1:1], 1'b0} : c_addr;
`endif
  assign be    = c_width[1] ? 4'hf : c_width[0] ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a[1:0];
  assign wdat  = c_width[1] ? c_data : c_width[0] ? {2{c_data[15:0]}} : {4{c_data[7:0]}};
  assign sh    = mem[a[AW+1:2]] >> {a[1:0], 3'b000};
  assign rd    = c_width[1] ? sh : c_width[0] ? {16'h0, sh[15:0]} : {24'h0, sh[7:0]};
  assign wr_en = enter & c_we & ~bad & nRst;
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        we_q    <= iWe;
        width_q <= iWidth;
        addr_q  <= iAddr[AW+1:0];
        data_q  <= iData;
      end
      if (enter) begin
        err_q   <= bad;
        rdata_q <= (c_we | bad) ? '0 : rd;
      end
    end
  end
  always_ff @(posedge iClk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en && be[i]) mem[a[AW+1:2]][8*i +: 8] <= wdat[8*i +: 8];
  end
  always_comb begin
    oAck  = (state == RESP) & ~err_q;
    oData = (state == RESP) ? rdata_q : '0;
`ifdef MISALIGN_ERR_EN
    oErr  = (state == RESP) & err_q;
`else
    oErr  = 1'b0;
`endif
  end
endmodule

// File: tb/tb_dmem_wb_ram.sv
// tb_dmem_wb_ram: directed scoreboard bench for dmem_wb_ram (WAIT_STATES=1 and 0 instances).
module tb_dmem_wb_ram;
`ifdef MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  logic clk = 1'b0;
  logic nrst;
  logic cyc, stb, we;
  logic [1:0] width;
  logic [31:0] addr, wdata, rdata;
  logic ack, err;
  logic z_cyc, z_stb, z_we;
  logic [1:0] z_width;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic z_ack, z_err;
  typedef struct { string tag; logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dmem_wb_ram #(.DEPTH(1024), .WAIT_STATES(1)) u1 (
    .iClk(clk), .nRst(nrst), .iCyc(cyc), .iStb(stb), .iWe(we), .iWidth(width),
    .iAddr(addr), .iData(wdata), .oData(rdata), .oAck(ack), .oErr(err)
  );
  dmem_wb_ram #(.DEPTH(64), .WAIT_STATES(0)) u0 (
    .iClk(clk), .nRst(nrst), .iCyc(z_cyc), .iStb(z_stb), .iWe(z_we), .iWidth(z_width),
    .iAddr(z_addr), .iData(z_wdata), .oData(z_rdata), .oAck(z_ack), .oErr(z_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One complete transaction on the WAIT_STATES=1 instance, request held until the response.
  task automatic txn(input logic w, input logic [1:0] wd, input logic [31:0] ad, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input string tag);
    int lat;
    exp_t e;
    if (!w || exp_e) sb.push_back('{tag, exp_e ? 32'h0 : exp_d, exp_e});
    cyc = 1'b1; stb = 1'b1; we = w; width = wd; addr = ad; wdata = d;
    @(posedge clk); #1;
    lat = 0;
    while (!(ack | err) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ack | err) begin
      chk({tag, "_lat"}, 32'(lat), 32'd1);
      chk({tag, "_ackerr"}, {30'h0, ack, err}, {30'h0, ~exp_e, exp_e});
      if (!w || exp_e) begin
        e = sb.pop_front();
        chk({e.tag, "_data"}, rdata, e.data);
      end
    end else begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      if (!w || exp_e) void'(sb.pop_front());
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {30'h0, ack, err}, 32'h0);
    chk({tag, "_idle_data"}, rdata, 32'h0);
  endtask
  task automatic count_acks(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack) hits++;
    end
    chk(tag, 32'(hits), 32'd0);
  endtask
  initial begin
    exp_t e;
    nrst = 1'b0;
    cyc = 0; stb = 0; we = 0; width = 0; addr = 0; wdata = 0;
    z_cyc = 0; z_stb = 0; z_we = 0; z_width = 0; z_addr = 0; z_wdata = 0;
    #3;
    chk("rst_out", {rdata[29:0], ack, err}, 32'h0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    chk("rst_z_out", {z_rdata[29:0], z_ack, z_err}, 32'h0);
    txn(1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 0, "w_deadbeef");
    txn(0, 2'd0, 32'h11, 0, 32'h000000BE, 0, "rb_11");
    txn(0, 2'd0, 32'h10, 0, 32'h000000EF, 0, "rb_10");
    txn(0, 2'd1, 32'h12, 0, 32'h0000DEAD, 0, "rh_12");
    txn(1, 2'd2, 32'h20, 32'hAAAAAAAA, 0, 0, "w_aaaa");
    txn(1, 2'd1, 32'h22, 32'hFFFF1234, 0, 0, "wh_1234");
    txn(0, 2'd2, 32'h20, 0, 32'h1234AAAA, 0, "rw_20");
    txn(0, 2'd1, 32'h22, 0, 32'h00001234, 0, "rh_22");
    txn(0, 2'd0, 32'h23, 0, 32'h00000012, 0, "rb_23");
    txn(0, 2'd2, 32'h1020, 0, 32'h1234AAAA, 0, "alias_1020");
    txn(1, 2'd2, 32'h8, 32'h11223344, 0, 0, "w_8");
    cyc = 1; stb = 1; we = 1; width = 2'd0; addr = 32'h8; wdata = 32'h55;
    @(posedge clk); #1;
    stb = 0; cyc = 0;
    count_acks("abort_noack", 4);
    txn(0, 2'd2, 32'h8, 0, 32'h11223344, 0, "abort_mem");
    txn(1, 2'd2, 32'hC, 32'h0BADF00D, 0, 0, "w_c");
    cyc = 1; stb = 1; we = 1; width = 2'd2; addr = 32'hC; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    nrst = 1'b0; cyc = 0; stb = 0;
    #2 chk("rst_mid_out", {rdata[29:0], ack, err}, 32'h0);
    #1 nrst = 1'b1;
    count_acks("rst_mid_noack", 3);
    txn(0, 2'd2, 32'hC, 0, 32'h0BADF00D, 0, "rst_mid_mem");
    txn(1, 2'd2, 32'h0, 32'hCAFEF00D, 0, 0, "w_0");
    txn(0, 2'd2, 32'h2, 0, 32'hCAFEF00D, MIS, "mis_word");
    txn(0, 2'd1, 32'h11, 0, 32'h0000BEEF, MIS, "mis_half");
    @(posedge clk); #1;
    z_cyc = 1; z_stb = 1; z_we = 1; z_width = 2'd2; z_addr = 32'h40; z_wdata = 32'h5A5AC3C3;
    @(posedge clk); #1;
    chk("b2b_wr_ack", {31'h0, z_ack}, 32'h1);
    z_we = 0;
    sb.push_back('{"b2b_rd", 32'h5A5AC3C3, 1'b0});
    @(posedge clk); #1;
    chk("b2b_gap", {31'h0, z_ack}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_rd_ack", {31'h0, z_ack}, 32'h1);
    e = sb.pop_front();
    chk({e.tag, "_data"}, z_rdata, e.data);
    z_cyc = 0; z_stb = 0;
    @(posedge clk); #1;
    chk("b2b_end", {30'h0, z_ack, z_err}, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
